sim_end_monitor: RTL and testbench

Parametrised end-of-test monitor for the RISC-V core. It observes the writeback retire stream, the register-file write port and the data-store bus, and detects test completion. Completion is one of three events: a store to a tohost address, a self-loop halt, or a cycle timeout. On completion it freezes the cycle and retired-instruction counters and reports pass, fail or timeout with an exit code. It sits beside cpu_top in simulation harnesses and in FPGA builds as a synthesizable status block.

---
 rtl/sim_end_monitor.sv | 166 ++++++++++++++++
 tb/tb_sim_end_monitor.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sim_end_monitor.sv
// sim_end_monitor: end-of-test detector (tohost store, self-loop halt, timeout).
// Optional PC history ring buffer is enabled by defining SIM_END_MONITOR_HIST_EN.
module sim_end_monitor #(
   parameter int               XLEN        = 32,
   parameter int               CNT_W       = 64,
   parameter int               TIMEOUT     = 1000000,
   parameter int               HALT_REPEAT = 3,
   parameter logic [XLEN-1:0]  TOHOST_ADDR = 32'h0000_1000,
   parameter int               HIST_DEPTH  = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             retire_valid,
   input  logic [XLEN-1:0]  retire_pc,
   input  logic             rd_we,
   input  logic [4:0]       rd_addr,
   input  logic [XLEN-1:0]  rd_data,
   input  logic             st_valid,
   input  logic [XLEN-1:0]  st_addr,
   input  logic [XLEN-1:0]  st_data,
   output logic             done,
   output logic             pass,
   output logic             fail,
   output logic             timeout,
   output logic [XLEN-1:0]  exit_code,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instret_cnt
`ifdef SIM_END_MONITOR_HIST_EN
   ,
   input  logic [$clog2(HIST_DEPTH)-1:0] hist_idx,
   output logic [XLEN-1:0]               hist_pc
`endif
);

   localparam int REP_W = $clog2(HALT_REPEAT + 1);

   typedef enum logic [1:0] {S_RUN, S_PASS, S_FAIL, S_TMO} state_e;

   state_e             state_q, state_d;
   logic [XLEN-1:0]    exit_q, exit_d;
   logic [XLEN-1:0]    gp_q, gp_d;
   logic [XLEN-1:0]    last_q, last_d;
   logic [REP_W-1:0]   rep_q, rep_d;
   logic [CNT_W-1:0]   cyc_q, cyc_d;
   logic [CNT_W-1:0]   inst_q, inst_d;
   logic               tohost_hit;
   logic               halt_hit;

   always_comb begin
      state_d    = state_q;
      exit_d     = exit_q;
      gp_d       = gp_q;
      last_d     = last_q;
      rep_d      = rep_q;
      cyc_d      = cyc_q;
      inst_d     = inst_q;
      halt_hit   = 1'b0;
      tohost_hit = st_valid && (st_addr == TOHOST_ADDR) && st_data[0];

      if (rd_we && (rd_addr == 5'd3)) gp_d = rd_data;

      if (state_q == S_RUN) begin
         cyc_d = cyc_q + 1'b1;
         if (retire_valid) begin
            inst_d = inst_q + 1'b1;
            if (retire_pc == last_q) begin
               if (rep_q != {REP_W{1'b1}}) rep_d = rep_q + 1'b1;
            end else begin
               rep_d  = REP_W'(1);
               last_d = retire_pc;
            end
            halt_hit = (rep_d == REP_W'(HALT_REPEAT));
         end
         // tohost beats halt beats timeout when they coincide
         if (tohost_hit) begin
            if (st_data == XLEN'(1)) begin
               state_d = S_PASS;
            end else begin
               state_d = S_FAIL;
               exit_d  = st_data >> 1;
            end
         end else if (halt_hit) begin
            if (gp_q == XLEN'(1)) begin
               state_d = S_PASS;
            end else begin
               state_d = S_FAIL;
               exit_d  = gp_q >> 1;
            end
         end else if (cyc_q == CNT_W'(TIMEOUT - 1)) begin
            state_d = S_TMO;
         end
      end

      if (clear) begin
         state_d = S_RUN;
         exit_d  = '0;
         gp_d    = '0;
         last_d  = '0;
         rep_d   = '0;
         cyc_d   = '0;
         inst_d  = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_RUN;
         exit_q  <= '0;
         gp_q    <= '0;
         last_q  <= '0;
         rep_q   <= '0;
         cyc_q   <= '0;
         inst_q  <= '0;
      end else begin
         state_q <= state_d;
         exit_q  <= exit_d;
         gp_q    <= gp_d;
         last_q  <= last_d;
         rep_q   <= rep_d;
         cyc_q   <= cyc_d;
         inst_q  <= inst_d;
      end
   end

   assign done        = (state_q != S_RUN);
   assign pass        = (state_q == S_PASS);
   assign fail        = (state_q == S_FAIL);
   assign timeout     = (state_q == S_TMO);
   assign exit_code   = exit_q;
   assign cycle_cnt   = cyc_q;
   assign instret_cnt = inst_q;

`ifdef SIM_END_MONITOR_HIST_EN
   localparam int AW = $clog2(HIST_DEPTH);

   logic [XLEN-1:0] hist_q [HIST_DEPTH];
   logic [AW-1:0]   wptr_q;
   logic [XLEN-1:0] hist_pc_q;

   // wptr_q points at the slot to be written next, so newest is wptr_q-1
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < HIST_DEPTH; i++) hist_q[i] <= '0;
         wptr_q    <= '0;
         hist_pc_q <= '0;
      end else if (clear) begin
         for (int i = 0; i < HIST_DEPTH; i++) hist_q[i] <= '0;
         wptr_q    <= '0;
         hist_pc_q <= '0;
      end else begin
         if ((state_q == S_RUN) && retire_valid) begin
            hist_q[wptr_q] <= retire_pc;
            wptr_q         <= wptr_q + 1'b1;
         end
         hist_pc_q <= hist_q[wptr_q - AW'(1) - hist_idx];
      end
   end

   assign hist_pc = hist_pc_q;
`else
   logic unused_hist;
   assign unused_hist = ^HIST_DEPTH;
`endif

endmodule

// File: tb/tb_sim_end_monitor.sv
// tb_sim_end_monitor: directed + randomized checks of sim_end_monitor
// against a queue-based reference model.
module tb_sim_end_monitor;

   localparam int          TMO    = 100;
   localparam int          HREP   = 3;
   localparam logic [31:0] TOHOST = 32'h0000_1000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clear = 1'b0;
   logic        retire_valid = 1'b0;
   logic [31:0] retire_pc = '0;
   logic        rd_we = 1'b0;
   logic [4:0]  rd_addr = '0;
   logic [31:0] rd_data = '0;
   logic        st_valid = 1'b0;
   logic [31:0] st_addr = '0;
   logic [31:0] st_data = '0;
   logic        done, pass, fail, timeout;
   logic [31:0] exit_code;
   logic [63:0] cycle_cnt, instret_cnt;
`ifdef SIM_END_MONITOR_HIST_EN
   logic [1:0]  hist_idx = '0;
   logic [31:0] hist_pc;
`endif

   sim_end_monitor #(
      .XLEN(32), .CNT_W(64), .TIMEOUT(TMO), .HALT_REPEAT(HREP),
      .TOHOST_ADDR(TOHOST), .HIST_DEPTH(4)
   ) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .retire_valid(retire_valid), .retire_pc(retire_pc),
      .rd_we(rd_we), .rd_addr(rd_addr), .rd_data(rd_data),
      .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
      .done(done), .pass(pass), .fail(fail), .timeout(timeout),
      .exit_code(exit_code), .cycle_cnt(cycle_cnt),
      .instret_cnt(instret_cnt)
`ifdef SIM_END_MONITOR_HIST_EN
      , .hist_idx(hist_idx), .hist_pc(hist_pc)
`endif
   );

   always #5 clk = ~clk;

   int ntot = 0;
   int npass = 0;

   // model: 0 run, 1 pass, 2 fail, 3 timeout
   int          m_state;
   logic [31:0] m_exit, m_gp;
   longint      m_cyc, m_inst;
   logic [31:0] pcq[$];

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      ntot++;
      assert (obs === exp) npass++;
      else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
   endtask

   task automatic model_reset();
      m_state = 0;
      m_exit  = '0;
      m_gp    = '0;
      m_cyc   = 0;
      m_inst  = 0;
      pcq.delete();
   endtask

   function automatic int runlen();
      int n = 0;
      for (int i = pcq.size() - 1; i >= 0; i--) begin
         if (pcq[i] != pcq[pcq.size()-1]) break;
         n++;
      end
      return n;
   endfunction

   task automatic model_step();
      logic [31:0] gpv = m_gp;
      bit th, ht;
      if (m_state == 0) begin
         th = st_valid && (st_addr == TOHOST) && st_data[0];
         ht = 1'b0;
         if (retire_valid) begin
            pcq.push_back(retire_pc);
            m_inst++;
            ht = (runlen() == HREP);
         end
         m_cyc++;
         if (th) begin
            if (st_data == 32'd1) m_state = 1;
            else begin m_state = 2; m_exit = st_data >> 1; end
         end else if (ht) begin
            if (gpv == 32'd1) m_state = 1;
            else begin m_state = 2; m_exit = gpv >> 1; end
         end else if (m_cyc == TMO) begin
            m_state = 3;
         end
      end
      if (rd_we && rd_addr == 5'd3) m_gp = rd_data;
      if (clear) model_reset();
   endtask

   task automatic cyc();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      clear        = 1'b0;
      retire_valid = 1'b0;
      rd_we        = 1'b0;
      st_valid     = 1'b0;
   endtask

   task automatic do_clear();
      idle();
      clear = 1'b1;
      cyc();
      clear = 1'b0;
   endtask

   task automatic store(logic [31:0] d);
      st_valid = 1'b1;
      st_addr  = TOHOST;
      st_data  = d;
   endtask

   task automatic chk_model(string t);
      chk({t, "_done"}, 64'(done), 64'(m_state != 0));
      chk({t, "_pass"}, 64'(pass), 64'(m_state == 1));
      chk({t, "_fail"}, 64'(fail), 64'(m_state == 2));
      chk({t, "_tmo"}, 64'(timeout), 64'(m_state == 3));
      chk({t, "_exit"}, 64'(exit_code), 64'(m_exit));
      chk({t, "_cyc"}, cycle_cnt, 64'(m_cyc));
      chk({t, "_inst"}, instret_cnt, 64'(m_inst));
   endtask

   task automatic halt_run(logic [31:0] gpval);
      do_clear();
      rd_we = 1'b1; rd_addr = 5'd3; rd_data = gpval;
      cyc();
      rd_we = 1'b0;
      retire_valid = 1'b1; retire_pc = 32'h8000_0040;
      cyc();
      cyc();
      chk("halt_pre_done", 64'(done), 64'd0);
      cyc();
      idle();
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      chk_model("reset");
      chk("reset_cyc", cycle_cnt, 64'd0);

      // tohost pass at cycle 50 after 40 retirements
      for (int i = 0; i < 50; i++) begin
         retire_valid = (i < 40);
         retire_pc    = 32'h100 + 32'(4 * i);
         cyc();
      end
      retire_valid = 1'b0;
      store(32'd1);
      cyc();
      idle();
      chk("t1_done", 64'(done), 64'd1);
      chk("t1_pass", 64'(pass), 64'd1);
      chk("t1_cyc", cycle_cnt, 64'd51);
      chk("t1_inst", instret_cnt, 64'd40);
      chk("t1_exit", 64'(exit_code), 64'd0);
      chk_model("t1");
      retire_valid = 1'b1; retire_pc = 32'h5; store(32'd7);
      repeat (3) cyc();
      idle();
      chk("t1_hold_cyc", cycle_cnt, 64'd51);
      chk("t1_hold_fail", 64'(fail), 64'd0);
      chk_model("t1_hold");

      // even store ignored, odd non-1 fails
      do_clear();
      chk_model("clr1");
      store(32'd4);
      cyc();
      chk("t2_even_done", 64'(done), 64'd0);
      store(32'd7);
      cyc();
      idle();
      chk("t2_fail", 64'(fail), 64'd1);
      chk("t2_exit", 64'(exit_code), 64'd3);
      chk_model("t2");

      halt_run(32'd1);
      chk("t3_pass", 64'(pass), 64'd1);
      chk_model("t3");
      halt_run(32'd9);
      chk("t4_fail", 64'(fail), 64'd1);
      chk("t4_exit", 64'(exit_code), 64'd4);
      chk_model("t4");

      // timeout
      do_clear();
      repeat (99) cyc();
      chk("t5_pre_done", 64'(done), 64'd0);
      cyc();
      chk("t5_tmo", 64'(timeout), 64'd1);
      chk("t5_cyc", cycle_cnt, 64'd100);
      cyc();
      chk("t5_hold_cyc", cycle_cnt, 64'd100);
      chk_model("t5");

      // tohost wins over timeout on the last cycle
      do_clear();
      repeat (99) cyc();
      store(32'd1);
      cyc();
      idle();
      chk("t6_pass", 64'(pass), 64'd1);
      chk("t6_tmo", 64'(timeout), 64'd0);
      chk("t6_cyc", cycle_cnt, 64'd100);

      // mid-run clear
      do_clear();
      repeat (30) cyc();
      chk("t7_cyc30", cycle_cnt, 64'd30);
      do_clear();
      chk_model("t7_clr");
      repeat (5) cyc();
      chk("t7_cyc5", cycle_cnt, 64'd5);

      // asynchronous reset mid-run
      retire_valid = 1'b1; retire_pc = 32'h200;
      repeat (10) begin cyc(); retire_pc += 32'd4; end
      idle();
      #2 rst_n = 1'b0;
      #1;
      chk("t8_cyc", cycle_cnt, 64'd0);
      chk("t8_inst", instret_cnt, 64'd0);
      chk("t8_done", 64'(done), 64'd0);
      model_reset();
      rst_n = 1'b1;
      cyc();
      chk_model("t8_after");

`ifdef SIM_END_MONITOR_HIST_EN
      do_clear();
      chk("h_clr", 64'(hist_pc), 64'd0);
      for (int i = 0; i < 6; i++) begin
         retire_valid = 1'b1;
         retire_pc    = 32'(4 * i);
         cyc();
      end
      idle();
      hist_idx = 2'd0;
      cyc();
      chk("h_idx0", 64'(hist_pc), 64'(pcq[pcq.size()-1]));
      chk("h_idx0_k", 64'(hist_pc), 64'h14);
      hist_idx = 2'd3;
      cyc();
      chk("h_idx3", 64'(hist_pc), 64'h8);
`endif

      // randomized runs
      for (int t = 0; t < 10; t++) begin
         do_clear();
         for (int c = 0; c < 130 && m_state == 0; c++) begin
            retire_valid = ($urandom_range(0, 9) < 6);
            retire_pc    = $urandom_range(0, 1) ? 32'h40 : 32'h44;
            rd_we        = ($urandom_range(0, 3) == 0);
            rd_addr      = 5'($urandom_range(0, 4));
            case ($urandom_range(0, 3))
               0:       rd_data = 32'd1;
               1:       rd_data = 32'd9;
               default: rd_data = $urandom;
            endcase
            st_valid = ($urandom_range(0, 15) == 0);
            st_addr  = $urandom_range(0, 1) ? TOHOST : 32'h2000;
            case ($urandom_range(0, 2))
               0:       st_data = 32'd1;
               1:       st_data = $urandom | 32'd1;
               default: st_data = $urandom & ~32'd1;
            endcase
            cyc();
            chk("rnd_done", 64'(done), 64'(m_state != 0));
         end
         idle();
         chk_model("rnd_end");
         cyc();
         chk_model("rnd_hold");
      end

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
